// File: rtl/scc_pkg.sv
// Shared types and constants for the SCC wave SRAM arbiter slice.
package scc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_MIX
    } owner_t;

    localparam logic [2:0]  SCC_CH_D    = 3'd3;
    localparam logic [2:0]  SCC_CH_E    = 3'd4;
    localparam int unsigned SCC_WAVE_AW = 5;

    // In SCC-compatible mode channel E shares the wave of channel D.
    function automatic logic [2:0] scc_map_id(input logic [2:0] id, input logic plus);
        return (!plus && (id == SCC_CH_E)) ? SCC_CH_D : id;
    endfunction

endpackage

// File: rtl/scc_arb_pick.sv
// Winner selection between CPU and mixer requests, plus the owner register.
// SCC_ARB_ROUND_ROBIN_EN selects alternating grants under contention;
// otherwise the mixer has fixed priority.
module scc_arb_pick
    import scc_pkg::*;
(
    input  logic   clk,
    input  logic   n_reset,
    input  logic   grant_en,
    input  logic   cpu_qual,
    input  logic   mix_qual,
    output logic   grant,
    output owner_t winner,
    output owner_t owner_q
);

    assign grant = grant_en && (cpu_qual || mix_qual);

`ifdef SCC_ARB_ROUND_ROBIN_EN
    owner_t ptr;

    // Contention is resolved by the pointer; a lone requester always wins.
    always_comb begin
        winner = OWN_CPU;
        if (cpu_qual && mix_qual) winner = ptr;
        else if (mix_qual)        winner = OWN_MIX;
    end

    // Pointer only moves when both requesters competed for the grant.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)                           ptr <= OWN_MIX;
        else if (grant && cpu_qual && mix_qual) ptr <= (ptr == OWN_MIX) ? OWN_CPU : OWN_MIX;
    end
`else
    // Mixer wins every simultaneous request.
    always_comb begin
        winner = mix_qual ? OWN_MIX : OWN_CPU;
    end
`endif

    // Remember who owns the access in flight.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)   owner_q <= OWN_MIX;
        else if (grant) owner_q <= winner;
    end

endmodule

// File: rtl/scc_wave_sram_arbiter.sv
// Sequencer/arbiter for the shared single-port SCC wave SRAM.
// Optional build macro: SCC_ARB_ROUND_ROBIN_EN (see scc_arb_pick).
module scc_wave_sram_arbiter
    import scc_pkg::*;
(
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   scc_plus,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [2:0]             cpu_id,
    input  logic [SCC_WAVE_AW-1:0] cpu_a,
    input  logic [7:0]             cpu_d,
    output logic                   cpu_ack,
    output logic [7:0]             cpu_q,
    input  logic                   mix_req,
    input  logic [2:0]             mix_id,
    input  logic [SCC_WAVE_AW-1:0] mix_a,
    output logic                   mix_ack,
    output logic [7:0]             mix_q,
    output logic [2:0]             sram_id,
    output logic [SCC_WAVE_AW-1:0] sram_a,
    output logic [7:0]             sram_d,
    output logic                   sram_oe,
    output logic                   sram_we,
    input  logic [7:0]             sram_q,
    output logic                   busy
);

    state_t                 state, state_nx;
    owner_t                 winner, owner_q;
    logic                   grant;
    logic                   cpu_qual, mix_qual;
    logic [2:0]             sel_id;
    logic [SCC_WAVE_AW-1:0] sel_a;
    logic                   sel_we;
    logic                   sel_nop;
    logic                   lat_nop;

    // A requester's level held through its own ack cycle is not a new request.
    assign cpu_qual = cpu_req && !cpu_ack;
    assign mix_qual = mix_req && !mix_ack;

    scc_arb_pick u_pick (
        .clk      (clk),
        .n_reset  (n_reset),
        .grant_en (state == IDLE),
        .cpu_qual (cpu_qual),
        .mix_qual (mix_qual),
        .grant    (grant),
        .winner   (winner),
        .owner_q  (owner_q)
    );

    // Request fields of the current winner, and whether it touches the SRAM at all.
    always_comb begin
        sel_id  = (winner == OWN_MIX) ? mix_id : cpu_id;
        sel_a   = (winner == OWN_MIX) ? mix_a  : cpu_a;
        sel_we  = (winner == OWN_CPU) && cpu_we;
        sel_nop = (sel_id > SCC_CH_E) || (sel_we && !scc_plus && (sel_id == SCC_CH_E));
    end

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (grant) state_nx = sel_we ? WR_ISSUE : RD_ISSUE;
            RD_ISSUE: state_nx = RD_WAIT;
            RD_WAIT:  state_nx = IDLE;
            WR_ISSUE: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Registered SRAM controls, acks and read data; strobes and acks are single-cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cpu_ack <= 1'b0;
            mix_ack <= 1'b0;
            cpu_q   <= '0;
            mix_q   <= '0;
            sram_id <= '0;
            sram_a  <= '0;
            sram_d  <= '0;
            sram_oe <= 1'b0;
            sram_we <= 1'b0;
            lat_nop <= 1'b0;
            busy    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            mix_ack <= 1'b0;
            sram_oe <= 1'b0;
            sram_we <= 1'b0;
            busy    <= (state_nx != IDLE);
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        sram_id <= scc_map_id(sel_id, scc_plus);
                        sram_a  <= sel_a;
                        lat_nop <= sel_nop;
                        if (sel_we) sram_d <= cpu_d;
                        if (!sel_nop) begin
                            sram_oe <= !sel_we;
                            sram_we <= sel_we;
                        end
                    end
                end
                RD_WAIT: begin
                    if (owner_q == OWN_CPU) begin
                        cpu_q   <= lat_nop ? 8'hFF : sram_q;
                        cpu_ack <= 1'b1;
                    end else begin
                        mix_q   <= lat_nop ? 8'hFF : sram_q;
                        mix_ack <= 1'b1;
                    end
                end
                WR_ISSUE: cpu_ack <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scc_wave_sram_arbiter.sv
// Directed bench for scc_wave_sram_arbiter with a synchronous SRAM model.
module tb_scc_wave_sram_arbiter;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       scc_plus = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [2:0] cpu_id = '0;
    logic [4:0] cpu_a = '0;
    logic [7:0] cpu_d = '0;
    logic       cpu_ack;
    logic [7:0] cpu_q;
    logic       mix_req = 1'b0;
    logic [2:0] mix_id = '0;
    logic [4:0] mix_a = '0;
    logic       mix_ack;
    logic [7:0] mix_q;
    logic [2:0] sram_id;
    logic [4:0] sram_a;
    logic [7:0] sram_d;
    logic       sram_oe, sram_we;
    logic [7:0] sram_q = '0;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    scc_wave_sram_arbiter dut (
        .clk(clk), .n_reset(n_reset), .scc_plus(scc_plus),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_id(cpu_id), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_ack(cpu_ack), .cpu_q(cpu_q),
        .mix_req(mix_req), .mix_id(mix_id), .mix_a(mix_a), .mix_ack(mix_ack), .mix_q(mix_q),
        .sram_id(sram_id), .sram_a(sram_a), .sram_d(sram_d), .sram_oe(sram_oe), .sram_we(sram_we),
        .sram_q(sram_q), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i, input int j);
        return 8'((i * 32 + j) ^ 8'h5A);
    endfunction

    // SRAM model: read data appears the cycle after the read strobe.
    logic [7:0] mem [0:4][0:31];
    logic       loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 32; j++)
                    mem[i][j] <= pat(i, j);
            loaded <= 1'b1;
        end else begin
            if (sram_we && sram_id <= 3'd4) mem[int'(sram_id)][int'(sram_a)] <= sram_d;
            if (sram_oe) sram_q <= (sram_id <= 3'd4) ? mem[int'(sram_id)][int'(sram_a)] : 8'h00;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // stb: 0 = no strobe expected, 1 = read strobe, 2 = write strobe
    typedef struct {
        logic       mix;
        logic       we;
        logic       plus;
        logic [2:0] id;
        logic [4:0] a;
        logic [7:0] d;
        int         stb;
        logic [2:0] sid;
        logic [7:0] q;
    } vec_t;

    function automatic vec_t mk(input logic mix, input logic we, input logic plus,
                                input logic [2:0] id, input logic [4:0] a, input logic [7:0] d,
                                input int stb, input logic [2:0] sid, input logic [7:0] q);
        vec_t v;
        v.mix = mix; v.we = we; v.plus = plus; v.id = id; v.a = a; v.d = d;
        v.stb = stb; v.sid = sid; v.q = q;
        return v;
    endfunction

    task automatic run_vec(input int k, input vec_t v);
        int c = 0, ack_c = -1, nstb = 0, both = 0, other = 0, extra = 0;
        int kind = 0;
        logic [2:0] sid = '0;
        logic [4:0] sa = '0;
        logic [7:0] sd = '0, q = '0;
        scc_plus = v.plus;
        if (v.mix) begin
            mix_req = 1'b1; mix_id = v.id; mix_a = v.a;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_id = v.id; cpu_a = v.a; cpu_d = v.d;
        end
        while (ack_c < 0 && c < 12) begin
            @(negedge clk);
            c++;
            if (sram_oe || sram_we) begin
                nstb++; sid = sram_id; sa = sram_a; sd = sram_d;
                kind = sram_we ? 2 : 1;
            end
            if (sram_oe && sram_we) both++;
            if (v.mix ? cpu_ack : mix_ack) other++;
            if (v.mix ? mix_ack : cpu_ack) begin
                ack_c = c;
                q = v.mix ? mix_q : cpu_q;
            end
        end
        // Request stays high through the ack cycle, then drops.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin cpu_req = 1'b0; mix_req = 1'b0; end
            if (sram_oe || sram_we || cpu_ack || mix_ack) extra++;
        end
        check($sformatf("v%0d ack latency", k), ack_c, v.we ? 2 : 3);
        check($sformatf("v%0d strobe count", k), nstb, (v.stb == 0) ? 0 : 1);
        check($sformatf("v%0d both strobes", k), both, 0);
        check($sformatf("v%0d other ack", k), other, 0);
        check($sformatf("v%0d post-ack activity", k), extra, 0);
        if (v.stb != 0) begin
            check($sformatf("v%0d strobe kind", k), kind, v.stb);
            check($sformatf("v%0d sram_id", k), int'(sid), int'(v.sid));
            check($sformatf("v%0d sram_a", k), int'(sa), int'(v.a));
            if (v.we) check($sformatf("v%0d sram_d", k), int'(sd), int'(v.d));
        end
        if (!v.we) check($sformatf("v%0d read data", k), int'(q), int'(v.q));
    endtask

    vec_t vt [14];

    initial begin
        vt[0]  = mk(0, 1, 1, 3'd2, 5'd5,  8'h3C, 2, 3'd2, 8'h00);
        vt[1]  = mk(0, 0, 1, 3'd2, 5'd5,  8'h00, 1, 3'd2, 8'h3C);
        vt[2]  = mk(1, 0, 0, 3'd4, 5'd7,  8'h00, 1, 3'd3, pat(3, 7));
        vt[3]  = mk(1, 0, 1, 3'd4, 5'd7,  8'h00, 1, 3'd4, pat(4, 7));
        vt[4]  = mk(0, 1, 0, 3'd4, 5'd9,  8'h77, 0, 3'd0, 8'h00);
        vt[5]  = mk(0, 0, 1, 3'd4, 5'd9,  8'h00, 1, 3'd4, pat(4, 9));
        vt[6]  = mk(0, 0, 1, 3'd6, 5'd1,  8'h00, 0, 3'd0, 8'hFF);
        vt[7]  = mk(0, 1, 1, 3'd7, 5'd2,  8'h11, 0, 3'd0, 8'h00);
        vt[8]  = mk(1, 0, 1, 3'd0, 5'd31, 8'h00, 1, 3'd0, pat(0, 31));
        vt[9]  = mk(0, 0, 0, 3'd4, 5'd0,  8'h00, 1, 3'd3, pat(3, 0));
        vt[10] = mk(0, 1, 0, 3'd3, 5'd0,  8'hC3, 2, 3'd3, 8'h00);
        vt[11] = mk(1, 0, 1, 3'd3, 5'd0,  8'h00, 1, 3'd3, 8'hC3);
        vt[12] = mk(1, 0, 1, 3'd5, 5'd3,  8'h00, 0, 3'd0, 8'hFF);
        vt[13] = mk(0, 0, 1, 3'd4, 5'd9,  8'h00, 1, 3'd4, pat(4, 9));

        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("reset ctrl", int'({cpu_ack, mix_ack, sram_id, sram_a, sram_oe, sram_we, busy}), 0);
        check("reset data", int'({cpu_q, mix_q, sram_d}), 0);

        for (int k = 0; k < 14; k++) run_vec(k, vt[k]);

        // Simultaneous reads, four rounds: CPU reads id 1, mixer reads id 0.
        for (int r = 0; r < 4; r++) begin
            int first = -1, nstb = 0, ca = 0, ma = 0, exp_first;
            scc_plus = 1'b1;
            cpu_we = 1'b0; cpu_id = 3'd1; cpu_a = 5'd2; cpu_req = 1'b1;
            mix_id = 3'd0; mix_a = 5'd3; mix_req = 1'b1;
            for (int c = 0; c < 16 && !(ca != 0 && ma != 0); c++) begin
                @(negedge clk);
                if (sram_oe) begin
                    nstb++;
                    if (first < 0) first = int'(sram_id);
                end
                if (cpu_ack) begin ca = 1; cpu_req = 1'b0; end
                if (mix_ack) begin ma = 1; mix_req = 1'b0; end
            end
            cpu_req = 1'b0; mix_req = 1'b0;
            @(negedge clk);
`ifdef SCC_ARB_ROUND_ROBIN_EN
            exp_first = (r % 2 == 0) ? 0 : 1;
`else
            exp_first = 0;
`endif
            check($sformatf("arb round %0d first grant id", r), first, exp_first);
            check($sformatf("arb round %0d strobes", r), nstb, 2);
            check($sformatf("arb round %0d both acked", r), ca + ma, 2);
        end

        // Reset while the read strobe is up: everything clears, no ack follows.
        begin
            int late = 0;
            cpu_we = 1'b0; cpu_id = 3'd1; cpu_a = 5'd4; cpu_req = 1'b1;
            @(negedge clk);
            check("mid-reset oe before", int'({sram_oe, busy}), 3);
            n_reset = 1'b0;
            #1;
            check("mid-reset ctrl", int'({cpu_ack, mix_ack, sram_id, sram_a, sram_oe, sram_we, busy}), 0);
            check("mid-reset data", int'({cpu_q, mix_q, sram_d}), 0);
            cpu_req = 1'b0;
            @(negedge clk);
            n_reset = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (cpu_ack || mix_ack || sram_oe || sram_we) late++;
            end
            check("post-reset activity", late, 0);
        end

        run_vec(14, vt[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
